compressor_core: RTL and testbench

Parametrised dynamic-range compressor for the sound-analysis audio path, and the successor to the fixed 12-bit compression stage. Works in the linear domain with no dB conversion. Each accepted sample updates a peak envelope with separate attack and release rates, then the block computes a gain from a programmable threshold and a 1:1/2:1/4:1/8:1 ratio. It sits between the ADC sample capture and the drum-trigger/audio-out stages, one `start` strobe per sample.

---
 rtl/compressor_core_if.sv | 40 ++++
 rtl/compressor_core.sv | 183 ++++++++++++++++++
 tb/tb_compressor_core.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/compressor_core_if.sv
// compressor_core_if: sample/control bundle between the capture stage and the
// compressor core.
//   master: drives start, incoming_sample, threshold, compression_amount
//           (and makeup_shift when COMPRESSION_MAKEUP_GAIN_EN is defined);
//           observes modified_sample, gain, envelope, busy, done.
//   slave : the compressor core side of the same signals.
// Parameters WIDTH and GAIN_FRAC must match the attached compressor_core.
interface compressor_core_if #(
  parameter int WIDTH     = 12,
  parameter int GAIN_FRAC = 10
);
  logic                    start;
  logic signed [WIDTH-1:0] incoming_sample;
  logic [WIDTH-2:0]        threshold;
  logic [1:0]              compression_amount;
`ifdef COMPRESSION_MAKEUP_GAIN_EN
  logic [1:0]              makeup_shift;
`endif
  logic signed [WIDTH-1:0] modified_sample;
  logic [GAIN_FRAC:0]      gain;
  logic [WIDTH-2:0]        envelope;
  logic                    busy;
  logic                    done;

  modport master (
`ifdef COMPRESSION_MAKEUP_GAIN_EN
    output makeup_shift,
`endif
    output start, incoming_sample, threshold, compression_amount,
    input  modified_sample, gain, envelope, busy, done
  );

  modport slave (
`ifdef COMPRESSION_MAKEUP_GAIN_EN
    input  makeup_shift,
`endif
    input  start, incoming_sample, threshold, compression_amount,
    output modified_sample, gain, envelope, busy, done
  );
endinterface

// File: rtl/compressor_core.sv
// compressor_core: linear-domain dynamic-range compressor. Each accepted
// sample updates a peak envelope (separate attack/release rates), derives a
// target level from threshold and ratio, divides it by the envelope to get a
// gain, and applies the gain to the captured sample.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - compressor_core_if.slave (start/sample/threshold/ratio in,
//           modified_sample/gain/envelope/busy/done out)
// Optional feature: COMPRESSION_MAKEUP_GAIN_EN adds makeup_shift, a saturating
// left shift of the output by 0..3.
//
// state | meaning
// IDLE  | waiting for start, outputs held
// ENV   | envelope update and knee target computation
// DIV   | restoring division, one gain bit per cycle (GAIN_FRAC+1 cycles)
// MUL   | apply gain, load outputs, pulse done
module compressor_core #(
  parameter int WIDTH         = 12,
  parameter int GAIN_FRAC     = 10,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 8
) (
  input logic              clock,
  input logic              reset,
  compressor_core_if.slave bus
);
  localparam int EW = WIDTH - 1;
  localparam int GW = GAIN_FRAC + 1;
  localparam int PW = WIDTH + GW + 1;
  localparam int CW = $clog2(GAIN_FRAC + 1);
  localparam logic [GW-1:0] UNITY = {1'b1, {GAIN_FRAC{1'b0}}};

  typedef enum logic [1:0] {IDLE, ENV, DIV, MUL} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] x_q;
  logic [EW-1:0]           thr_q;
  logic [1:0]              amt_q;
  logic [EW-1:0]           env_q;
  logic                    unity_q;
  logic [WIDTH-1:0]        rem_q;
  logic [GW-1:0]           quo_q;
  logic [CW-1:0]           cnt_q;
  logic signed [WIDTH-1:0] mod_q;
  logic [GW-1:0]           gain_q;
  logic                    busy_q;
  logic                    done_q;
`ifdef COMPRESSION_MAKEUP_GAIN_EN
  logic [1:0]              ms_q;
  logic signed [WIDTH+3:0] wide;
`endif

  logic signed [WIDTH-1:0] neg_x;
  logic [EW-1:0]           abs_x;
  logic [EW-1:0]           diff;
  logic [EW-1:0]           env_next;
  logic [EW-1:0]           lvl_next;
  logic                    unity_next;
  logic                    q_bit;
  logic [WIDTH-1:0]        rem_sub;
  logic [WIDTH-1:0]        rem_next;
  logic [GW-1:0]           g_final;
  logic signed [PW-1:0]    prod;
  logic signed [WIDTH-1:0] base;
  logic signed [WIDTH-1:0] mod_next;
  logic                    calc_unused;

  always_comb begin
    // |x| with the most negative code clamped to full scale
    neg_x = -x_q;
    abs_x = x_q[EW-1:0];
    if (x_q[WIDTH-1]) begin
      if (x_q == {1'b1, {EW{1'b0}}}) abs_x = {EW{1'b1}};
      else                           abs_x = neg_x[EW-1:0];
    end

    if (abs_x > env_q) begin
      diff     = abs_x - env_q;
      env_next = env_q + (diff >> ATTACK_SHIFT);
    end else begin
      diff     = env_q - abs_x;
      env_next = env_q - (diff >> RELEASE_SHIFT);
    end

    // the ratio code doubles as the knee shift (01->1, 10->2, 11->3)
    if (env_next <= thr_q || amt_q == 2'd0) begin
      lvl_next   = env_next;
      unity_next = 1'b1;
    end else begin
      lvl_next   = thr_q + ((env_next - thr_q) >> amt_q);
      unity_next = 1'b0;
    end

    // L <= e, so the quotient fits GAIN_FRAC+1 bits and the remainder never
    // needs more than WIDTH bits after the doubling shift
    q_bit    = (rem_q >= {1'b0, env_q});
    rem_sub  = q_bit ? (rem_q - {1'b0, env_q}) : rem_q;
    rem_next = {rem_sub[WIDTH-2:0], 1'b0};

    g_final = unity_q ? UNITY : quo_q;
    prod    = PW'(x_q) * PW'($signed({1'b0, g_final}));
    base    = prod[GAIN_FRAC +: WIDTH];

`ifdef COMPRESSION_MAKEUP_GAIN_EN
    wide = (WIDTH+4)'(base) <<< ms_q;
    if (wide[WIDTH+3:WIDTH-1] != {5{wide[WIDTH+3]}})
      mod_next = wide[WIDTH+3] ? {1'b1, {EW{1'b0}}} : {1'b0, {EW{1'b1}}};
    else
      mod_next = wide[WIDTH-1:0];
`else
    mod_next = base;
`endif

    calc_unused = ^{neg_x[WIDTH-1], rem_sub[WIDTH-1], prod[GAIN_FRAC-1:0],
                    prod[PW-1:WIDTH+GAIN_FRAC]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      x_q     <= '0;
      thr_q   <= '0;
      amt_q   <= '0;
      env_q   <= '0;
      unity_q <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      mod_q   <= '0;
      gain_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef COMPRESSION_MAKEUP_GAIN_EN
      ms_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_q    <= bus.incoming_sample;
            thr_q  <= bus.threshold;
            amt_q  <= bus.compression_amount;
`ifdef COMPRESSION_MAKEUP_GAIN_EN
            ms_q   <= bus.makeup_shift;
`endif
            busy_q <= 1'b1;
            state  <= ENV;
          end
        end
        ENV: begin
          env_q   <= env_next;
          unity_q <= unity_next;
          rem_q   <= {1'b0, lvl_next};
          quo_q   <= '0;
          cnt_q   <= CW'(GAIN_FRAC);
          state   <= DIV;
        end
        DIV: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[GW-2:0], q_bit};
          if (cnt_q == '0) state <= MUL;
          else             cnt_q <= cnt_q - CW'(1);
        end
        MUL: begin
          mod_q  <= mod_next;
          gain_q <= g_final;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.modified_sample = mod_q;
  assign bus.gain            = gain_q;
  assign bus.envelope        = env_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
endmodule

// File: tb/tb_compressor_core.sv
// tb_compressor_core: directed scoreboard bench for compressor_core
// (WIDTH=12, GAIN_FRAC=10, ATTACK_SHIFT=0, RELEASE_SHIFT=2).
// The driver pushes hand-computed results per accepted sample; the monitor
// pops and compares on every done pulse, including the cycle it arrives on.
module tb_compressor_core;
  localparam int WIDTH = 12;
  localparam int GF    = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;

  compressor_core_if #(.WIDTH(WIDTH), .GAIN_FRAC(GF)) bus ();

  compressor_core #(
    .WIDTH(WIDTH), .GAIN_FRAC(GF), .ATTACK_SHIFT(0), .RELEASE_SHIFT(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    int mod;
    int gain;
    int env;
    int due;
    int id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   dones  = 0;
  int   pushed = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // monitor: samples on the falling edge, away from the active edge
  always @(negedge clock) begin
    exp_t e;
    if (reset && bus.done) begin
      dones++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_mod", e.id), int'(bus.modified_sample), e.mod);
        check($sformatf("v%0d_gain", e.id), int'(bus.gain), e.gain);
        check($sformatf("v%0d_env", e.id), int'(bus.envelope), e.env);
        check($sformatf("v%0d_latency", e.id), cyc, e.due);
      end
    end
  end

  task automatic send(input int x, input int thr, input int amt, input int ms,
                      input bit expect_done, input int e_mod, input int e_gain,
                      input int e_env);
    exp_t e;
    int   n;
    @(negedge clock);
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (bus.busy) check("busy_timeout", 1, 0);
    bus.incoming_sample    = 12'(x);
    bus.threshold          = 11'(thr);
    bus.compression_amount = 2'(amt);
`ifdef COMPRESSION_MAKEUP_GAIN_EN
    bus.makeup_shift       = 2'(ms);
`endif
    bus.start = 1'b1;
    if (expect_done) begin
      e.mod  = e_mod;
      e.gain = e_gain;
      e.env  = e_env;
      e.due  = cyc + 1 + GF + 3;
      e.id   = pushed;
      sb.push_back(e);
      pushed++;
    end
    @(negedge clock);
    bus.start = 1'b0;
    // scramble live inputs; only the captured values may matter
    bus.incoming_sample    = 12'h5A5;
    bus.threshold          = '0;
    bus.compression_amount = 2'b11;
`ifdef COMPRESSION_MAKEUP_GAIN_EN
    bus.makeup_shift       = 2'b11;
`endif
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    drain();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mod"},  int'(bus.modified_sample), 0);
    check({tag, "_gain"}, int'(bus.gain), 0);
    check({tag, "_env"},  int'(bus.envelope), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    bus.start              = 1'b0;
    bus.incoming_sample    = '0;
    bus.threshold          = '0;
    bus.compression_amount = '0;
`ifdef COMPRESSION_MAKEUP_GAIN_EN
    bus.makeup_shift       = '0;
`endif
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset = 1'b1;

    // bypass: 1:1 forces unity
    send(1000, 0, 0, 0, 1, 1000, 1024, 1000);
    pulse_reset();

    // 2:1 knee at 512, instant attack
    send(1536, 512, 1, 0, 1, 1023, 682, 1536);
    send(-1536, 512, 1, 0, 1, -1023, 682, 1536);
    // -2048 clamps to 2047; e <= T gives unity
    send(-2048, 2047, 3, 0, 1, -2048, 1024, 2047);
    pulse_reset();

    // release by (e-a)>>2
    send(1024, 2047, 0, 0, 1, 1024, 1024, 1024);
    send(0, 2047, 0, 0, 1, 0, 1024, 768);
    // 4:1: e=601, L=342, g=582, 100*582>>10=56
    send(100, 256, 2, 0, 1, 56, 582, 601);
    // 8:1: e=703, L=175, g=254, -703*254 floors to -175
    send(-703, 100, 3, 0, 1, -175, 254, 703);

    // start while busy is ignored
    send(500, 2047, 0, 0, 1, 500, 1024, 653);
    repeat (4) @(negedge clock);
    bus.incoming_sample = -12'sd2000;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    drain();

    // reset mid-DIV aborts the operation
    send(1000, 2047, 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    check_zero("abort");
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("abort_idle_busy", int'(bus.busy), 0);

    send(1000, 2047, 0, 0, 1, 1000, 1024, 1000);

`ifdef COMPRESSION_MAKEUP_GAIN_EN
    send(1500, 2047, 0, 1, 1, 2047, 1024, 1500);
    send(-600, 2047, 0, 1, 1, -1200, 1024, 1275);
`endif

    drain();
    repeat (5) @(negedge clock);
    check("done_count", dones, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
